siaminer_resp_tx: RTL and testbench



---
 rtl/siaminer_pkg.sv | 23 ++
 rtl/siaminer_sync_fifo.sv | 60 ++++++
 rtl/siaminer_resp_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_siaminer_resp_tx.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/siaminer_pkg.sv
// Shared constants and types for the siaminer host link (command parser and response transmitter).
// Frame layout: header, cmd, len, then payload bytes least-significant first.
package siaminer_pkg;

    localparam logic [7:0] RESP_HEADER = 8'h55;
    localparam logic [7:0] REQ_HEADER  = 8'hAA;

    localparam logic [7:0] CMD_WORK = 8'h00;
    localparam logic [7:0] CMD_LOOP = 8'h01;

    localparam int NONCE_LEN = 4;
    localparam int WORK_LEN  = 88;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_GAP
    } resp_state_t;

endpackage

// File: rtl/siaminer_sync_fifo.sv
// Single-clock FIFO with full/empty flags and first-word-fall-through read data.
// DEPTH must be a power of two so the pointers wrap naturally.
module siaminer_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    // Flags come from registered occupancy only, so a full FIFO refuses a push
    // even when a pop happens in the same cycle.
    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/siaminer_resp_tx.sv
// Host-bound response framer: nonce results (cmd 0x00) and loop-test echoes (cmd 0x01), one byte per UART handshake.
// Optional SIAMINER_RESP_STATS_EN adds saturating per-type frame counters.
module siaminer_resp_tx
    import siaminer_pkg::*;
#(
    parameter logic [7:0] HEADER      = RESP_HEADER,
    parameter int         LOOP_DEPTH  = 4,
    parameter int         NONCE_BYTES = NONCE_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nonce_valid,
    input  logic [31:0] nonce,
    output logic        nonce_ready,
    input  logic        loop_valid,
    input  logic [7:0]  loop_byte,
    output logic        loop_ready,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    output logic        tx_last_byte
`ifdef SIAMINER_RESP_STATS_EN
    ,
    output logic [15:0] nonce_frame_cnt,
    output logic [15:0] loop_frame_cnt
`endif
);

    localparam int PW = NONCE_BYTES * 8;
    localparam int CW = (NONCE_BYTES > 1) ? $clog2(NONCE_BYTES) : 1;
    localparam logic [CW-1:0] NONCE_CNT_INIT = CW'(NONCE_BYTES - 1);
    localparam logic [7:0]    NONCE_LEN_BYTE = 8'(NONCE_BYTES);

    resp_state_t    state_reg, state_next;
    resp_state_t    ret_reg, ret_next;

    logic           nonce_full_reg;
    logic [PW-1:0]  nonce_hold_reg;
    logic           is_loop_reg;
    logic [PW-1:0]  payload_reg;
    logic [CW-1:0]  byte_cnt_reg;
    logic [7:0]     tx_data_reg;
    logic           new_tx_data_reg;
    logic           tx_last_byte_reg;

    logic           issue;
    logic [7:0]     issue_byte;
    logic           issue_last;
    logic           start_nonce;
    logic           start_loop;
    logic           shift_payload;

    logic [7:0]     fifo_data;
    logic           fifo_full;
    logic           fifo_empty;

    siaminer_sync_fifo #(
        .WIDTH (8),
        .DEPTH (LOOP_DEPTH)
    ) u_loop_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (loop_valid),
        .push_data (loop_byte),
        .pop       (start_loop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign loop_ready   = !fifo_full;
    assign nonce_ready  = !nonce_full_reg;
    assign tx_data      = tx_data_reg;
    assign new_tx_data  = new_tx_data_reg;
    assign tx_last_byte = tx_last_byte_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            ret_reg   <= ST_IDLE;
        end else begin
            state_reg <= state_next;
            ret_reg   <= ret_next;
        end
    end

    // Every byte state issues only when the UART is free, then parks in GAP for
    // one cycle so the transmitter's busy flag has time to rise.
    always_comb begin
        state_next    = state_reg;
        ret_next      = ret_reg;
        issue         = 1'b0;
        issue_byte    = 8'h00;
        issue_last    = 1'b0;
        start_nonce   = 1'b0;
        start_loop    = 1'b0;
        shift_payload = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (nonce_full_reg) begin
                    start_nonce = 1'b1;
                    state_next  = ST_HDR;
                end else if (!fifo_empty) begin
                    start_loop = 1'b1;
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (!tx_busy) begin
                    issue      = 1'b1;
                    issue_byte = HEADER;
                    state_next = ST_GAP;
                    ret_next   = ST_CMD;
                end
            end
            ST_CMD: begin
                if (!tx_busy) begin
                    issue      = 1'b1;
                    issue_byte = is_loop_reg ? CMD_LOOP : CMD_WORK;
                    state_next = ST_GAP;
                    ret_next   = ST_LEN;
                end
            end
            ST_LEN: begin
                if (!tx_busy) begin
                    issue      = 1'b1;
                    issue_byte = is_loop_reg ? 8'd1 : NONCE_LEN_BYTE;
                    state_next = ST_GAP;
                    ret_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!tx_busy) begin
                    issue         = 1'b1;
                    issue_byte    = payload_reg[7:0];
                    shift_payload = 1'b1;
                    state_next    = ST_GAP;
                    if (byte_cnt_reg == '0) begin
                        issue_last = 1'b1;
                        ret_next   = ST_IDLE;
                    end else begin
                        ret_next = ST_DATA;
                    end
                end
            end
            ST_GAP: begin
                state_next = ret_reg;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Nonce holding register: freed on the same edge its value moves into the
    // frame shift register, so a new nonce can be taken while the frame is sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_full_reg <= 1'b0;
            nonce_hold_reg <= '0;
        end else if (start_nonce) begin
            nonce_full_reg <= 1'b0;
        end else if (nonce_valid && !nonce_full_reg) begin
            nonce_full_reg <= 1'b1;
            nonce_hold_reg <= PW'(nonce);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_loop_reg  <= 1'b0;
            payload_reg  <= '0;
            byte_cnt_reg <= '0;
        end else if (start_nonce) begin
            is_loop_reg  <= 1'b0;
            payload_reg  <= nonce_hold_reg;
            byte_cnt_reg <= NONCE_CNT_INIT;
        end else if (start_loop) begin
            is_loop_reg  <= 1'b1;
            payload_reg  <= PW'(fifo_data);
            byte_cnt_reg <= '0;
        end else if (shift_payload) begin
            payload_reg  <= payload_reg >> 8;
            byte_cnt_reg <= byte_cnt_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_reg      <= 8'h00;
            new_tx_data_reg  <= 1'b0;
            tx_last_byte_reg <= 1'b0;
        end else begin
            new_tx_data_reg  <= issue;
            tx_last_byte_reg <= issue_last;
            if (issue) begin
                tx_data_reg <= issue_byte;
            end
        end
    end

`ifdef SIAMINER_RESP_STATS_EN
    logic [15:0] nonce_cnt_reg;
    logic [15:0] loop_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_cnt_reg <= 16'h0000;
            loop_cnt_reg  <= 16'h0000;
        end else if (issue_last) begin
            if (is_loop_reg) begin
                if (loop_cnt_reg != 16'hFFFF) begin
                    loop_cnt_reg <= loop_cnt_reg + 16'd1;
                end
            end else begin
                if (nonce_cnt_reg != 16'hFFFF) begin
                    nonce_cnt_reg <= nonce_cnt_reg + 16'd1;
                end
            end
        end
    end

    assign nonce_frame_cnt = nonce_cnt_reg;
    assign loop_frame_cnt  = loop_cnt_reg;
`endif

endmodule

// File: tb/tb_siaminer_resp_tx.sv
// Randomized bench for siaminer_resp_tx: frame-level reference model, UART busy model, one line per byte strobe.
module tb_siaminer_resp_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nonce_valid;
    logic [31:0] nonce;
    logic        nonce_ready;
    logic        loop_valid;
    logic [7:0]  loop_byte;
    logic        loop_ready;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_last_byte;
`ifdef SIAMINER_RESP_STATS_EN
    logic [15:0] nonce_frame_cnt;
    logic [15:0] loop_frame_cnt;
`endif

    siaminer_resp_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .nonce_valid  (nonce_valid),
        .nonce        (nonce),
        .nonce_ready  (nonce_ready),
        .loop_valid   (loop_valid),
        .loop_byte    (loop_byte),
        .loop_ready   (loop_ready),
        .tx_busy      (tx_busy),
        .tx_data      (tx_data),
        .new_tx_data  (new_tx_data),
        .tx_last_byte (tx_last_byte)
`ifdef SIAMINER_RESP_STATS_EN
        ,
        .nonce_frame_cnt (nonce_frame_cnt),
        .loop_frame_cnt  (loop_frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Source-side queues (what the bench wants to send) and model queues (what the DUT accepted).
    logic [31:0] nonce_src_q[$];
    logic [7:0]  loop_src_q[$];
    logic [31:0] model_nonce_q[$];
    logic [7:0]  model_loop_q[$];
    logic [7:0]  exp_q[$];

    int busy_len = 0;
    bit stuck_busy = 0;
    bit saw_strobe = 0;
    int busy_left = 0;
    int cycle = 0;
    int last_strobe_cyc = -100;
    bit prev_strobe = 0;
    bit prev_busy = 0;
    int strobe_cnt = 0;
    int loop_acc_cnt = 0;
    int nonce_frames = 0;
    int loop_frames = 0;

    // Nonce source: holds valid until accepted.
    initial begin
        bit take_n;
        nonce_valid = 1'b0;
        nonce = 32'h0;
        forever begin
            @(negedge clk);
            take_n = nonce_valid && nonce_ready && rst_n;
            @(posedge clk);
            if (take_n && nonce_src_q.size() > 0) begin
                model_nonce_q.push_back(nonce_src_q.pop_front());
            end
            #1;
            if (nonce_src_q.size() > 0) begin
                nonce_valid = 1'b1;
                nonce = nonce_src_q[0];
            end else begin
                nonce_valid = 1'b0;
            end
        end
    end

    // Loop-byte source: holds valid until accepted.
    initial begin
        bit take_l;
        loop_valid = 1'b0;
        loop_byte = 8'h00;
        forever begin
            @(negedge clk);
            take_l = loop_valid && loop_ready && rst_n;
            @(posedge clk);
            if (take_l && loop_src_q.size() > 0) begin
                model_loop_q.push_back(loop_src_q.pop_front());
                loop_acc_cnt++;
            end
            #1;
            if (loop_src_q.size() > 0) begin
                loop_valid = 1'b1;
                loop_byte = loop_src_q[0];
            end else begin
                loop_valid = 1'b0;
            end
        end
    end

    // UART model: busy for busy_len cycles after each strobe, or held high while stuck_busy.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (saw_strobe) begin
                busy_left = busy_len;
                saw_strobe = 0;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            tx_busy = stuck_busy || (busy_left > 0);
        end
    end

    // Monitor: a new frame takes the pending nonce if any, otherwise the oldest echo byte.
    initial begin
        logic [31:0] v;
        logic [7:0]  b;
        logic [7:0]  e;
        forever begin
            @(negedge clk);
            cycle++;
            if (!rst_n) begin
                prev_strobe = 0;
                prev_busy = 0;
            end else begin
                if (new_tx_data) begin
                    strobe_cnt++;
                    saw_strobe = 1;
                    check_val("no_back_to_back", prev_strobe, 0);
                    check_val("busy_respected", prev_busy, 0);
                    if (exp_q.size() == 0) begin
                        if (model_nonce_q.size() > 0) begin
                            v = model_nonce_q.pop_front();
                            exp_q.push_back(8'h55);
                            exp_q.push_back(8'h00);
                            exp_q.push_back(8'h04);
                            for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
                            nonce_frames++;
                        end else if (model_loop_q.size() > 0) begin
                            b = model_loop_q.pop_front();
                            exp_q.push_back(8'h55);
                            exp_q.push_back(8'h01);
                            exp_q.push_back(8'h01);
                            exp_q.push_back(b);
                            loop_frames++;
                        end
                    end else if (busy_len == 0 && !stuck_busy) begin
                        check_val("gap_1cycle", cycle - last_strobe_cyc, 2);
                    end
                    check_val("frame_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        $display("cyc %0d: tx_data=%h last=%0b expected=%h last=%0b", cycle, tx_data, tx_last_byte, e, exp_q.size() == 0);
                        check_val("tx_data", tx_data, e);
                        check_val("tx_last_byte", tx_last_byte, exp_q.size() == 0);
                    end
                    last_strobe_cyc = cycle;
                end else if (tx_last_byte) begin
                    check_val("last_without_strobe", tx_last_byte, 0);
                end
                prev_strobe = new_tx_data;
                prev_busy = tx_busy;
            end
        end
    end

    task automatic wait_drain(input int budget);
        int pend;
        bit done;
        done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            pend = nonce_src_q.size() + loop_src_q.size() + model_nonce_q.size() + model_loop_q.size() + exp_q.size();
            if (pend == 0) done = 1;
        end
        pend = nonce_src_q.size() + loop_src_q.size() + model_nonce_q.size() + model_loop_q.size() + exp_q.size();
        if (!done) check_val("drain_timeout", pend, 0);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int a0;
        bit found;
        logic [31:0] r;

        // Reset values
        repeat (3) @(negedge clk);
        check_val("rst_new_tx_data", new_tx_data, 0);
        check_val("rst_tx_last_byte", tx_last_byte, 0);
        check_val("rst_tx_data", tx_data, 0);
        check_val("rst_nonce_ready", nonce_ready, 1);
        check_val("rst_loop_ready", loop_ready, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single nonce, no busy
        busy_len = 0;
        s0 = strobe_cnt;
        nonce_src_q.push_back(32'h1234ABCD);
        wait_drain(200);
        check_val("t1_strobes", strobe_cnt - s0, 7);

        // Two back-to-back loop bytes
        s0 = strobe_cnt;
        loop_src_q.push_back(8'h5A);
        loop_src_q.push_back(8'hC3);
        wait_drain(200);
        check_val("t2_strobes", strobe_cnt - s0, 8);

        // Simultaneous nonce and loop: nonce frame first
        s0 = strobe_cnt;
        nonce_src_q.push_back(32'h0000_0001);
        loop_src_q.push_back(8'h77);
        repeat (2) @(negedge clk);
        check_val("t3_nonce_ready_low", nonce_ready, 0);
        found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (new_tx_data) found = 1;
            else @(negedge clk);
        end
        check_val("t3_hdr_seen", found, 1);
        check_val("t3_nonce_ready_after_start", nonce_ready, 1);
        wait_drain(200);
        check_val("t3_strobes", strobe_cnt - s0, 11);

        // Long busy after each strobe
        busy_len = 20;
        s0 = strobe_cnt;
        nonce_src_q.push_back($urandom);
        loop_src_q.push_back(8'($urandom));
        wait_drain(2000);
        check_val("t4_strobes", strobe_cnt - s0, 11);
        busy_len = 0;

        // Nonce arriving mid loop frame waits, then beats the queued echo byte
        s0 = strobe_cnt;
        loop_src_q.push_back(8'($urandom));
        loop_src_q.push_back(8'($urandom));
        found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (new_tx_data) found = 1;
        end
        check_val("t5_first_strobe", found, 1);
        nonce_src_q.push_back($urandom);
        wait_drain(300);
        check_val("t5_strobes", strobe_cnt - s0, 15);

        // Stuck busy: FIFO fills behind the frame held in HDR
        stuck_busy = 1;
        repeat (2) @(negedge clk);
        s0 = strobe_cnt;
        a0 = loop_acc_cnt;
        for (int i = 0; i < 6; i++) loop_src_q.push_back(8'($urandom));
        repeat (20) @(negedge clk);
        check_val("t6_loop_ready_full", loop_ready, 0);
        check_val("t6_accepted", loop_acc_cnt - a0, 5);
        check_val("t6_no_strobe_busy", strobe_cnt - s0, 0);
        stuck_busy = 0;
        wait_drain(500);
        check_val("t6_strobes", strobe_cnt - s0, 24);

        // Randomized sequential traffic
        for (int it = 0; it < 12; it++) begin
            busy_len = $urandom_range(0, 3);
            s0 = strobe_cnt;
            if ($urandom_range(0, 1) == 1) begin
                nonce_src_q.push_back($urandom);
                wait_drain(300);
                check_val("rand_nonce_strobes", strobe_cnt - s0, 7);
            end else begin
                r = $urandom_range(1, 3);
                for (int k = 0; k < int'(r); k++) loop_src_q.push_back(8'($urandom));
                wait_drain(500);
                check_val("rand_loop_strobes", strobe_cnt - s0, 4 * r);
            end
        end
        busy_len = 0;

        // Reset during the 0xAB data byte
        nonce_src_q.push_back(32'h1234ABCD);
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (new_tx_data && tx_data == 8'hAB) found = 1;
        end
        check_val("rst_ab_seen", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_new_tx_data", new_tx_data, 0);
        check_val("mid_rst_tx_last_byte", tx_last_byte, 0);
        check_val("mid_rst_tx_data", tx_data, 0);
        check_val("mid_rst_nonce_ready", nonce_ready, 1);
        check_val("mid_rst_loop_ready", loop_ready, 1);
        exp_q.delete();
        model_nonce_q.delete();
        model_loop_q.delete();
        nonce_frames = 0;
        loop_frames = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s0 = strobe_cnt;
        repeat (30) @(negedge clk);
        check_val("post_rst_quiet", strobe_cnt - s0, 0);

        // Recovery after reset
        s0 = strobe_cnt;
        nonce_src_q.push_back($urandom);
        loop_src_q.push_back(8'($urandom));
        wait_drain(300);
        check_val("recover_strobes", strobe_cnt - s0, 11);

`ifdef SIAMINER_RESP_STATS_EN
        check_val("stats_nonce", nonce_frame_cnt, nonce_frames);
        check_val("stats_loop", loop_frame_cnt, loop_frames);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
